// File: rtl/branch_predictor_if.sv
// Fetch/EX-side bundle of the branch predictor.
// The pipeline drives the master side, the predictor the slave side.
interface branch_predictor_if #(
    parameter int ADDR_W = 24,
    parameter int STAT_W = 16
);
    logic              pred_taken;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] pred_next_pc;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_next_pc, mispredict, redirect_pc,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_next_pc, mispredict, redirect_pc,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters,
// misprediction detection and saturating statistics.
module branch_predictor #(
    parameter int ADDR_W  = 24,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [STAT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]   if_idx, ex_idx;
    logic [TAG_W-1:0]   if_tag, ex_tag;
    logic               if_hit, ex_hit, misp;
    logic               wr_en;
    logic               val_d;
    logic [TAG_W-1:0]   tag_d;
    logic [ADDR_W-1:0]  tgt_d;
    logic [1:0]         ctr_d;

    assign if_idx = bp.if_pc[IDX_W-1:0];
    assign if_tag = bp.if_pc[ADDR_W-1:IDX_W];
    assign ex_idx = bp.ex_pc[IDX_W-1:0];
    assign ex_tag = bp.ex_pc[ADDR_W-1:IDX_W];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign bp.pred_taken   = if_hit && ctr_q[if_idx][1];
    assign bp.pred_next_pc = bp.pred_taken ? tgt_q[if_idx]
                                           : bp.if_pc + ADDR_W'(1);

    assign misp = bp.ex_valid &&
                  ((bp.ex_taken != bp.ex_pred_taken) ||
                   (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));
    assign bp.mispredict  = misp;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target
                                        : bp.ex_pc + ADDR_W'(1);

    assign bp.branch_cnt  = branch_cnt_q;
    assign bp.mispred_cnt = mispred_cnt_q;

    always_comb begin
        wr_en = 1'b0;
        val_d = valid_q[ex_idx];
        tag_d = tag_q[ex_idx];
        tgt_d = tgt_q[ex_idx];
        ctr_d = ctr_q[ex_idx];
        if (bp.ex_valid) begin
            unique case (1'b1)
                ex_hit && bp.ex_taken: begin
                    wr_en = 1'b1;
                    ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3
                                                    : ctr_q[ex_idx] + 2'd1;
                    tgt_d = bp.ex_target;
                end
                ex_hit && !bp.ex_taken: begin
                    wr_en = 1'b1;
                    ctr_d = (ctr_q[ex_idx] == 2'd0) ? 2'd0
                                                    : ctr_q[ex_idx] - 2'd1;
                end
                // A taken miss evicts whatever aliases at this index.
                !ex_hit && bp.ex_taken: begin
                    wr_en = 1'b1;
                    val_d = 1'b1;
                    tag_d = ex_tag;
                    tgt_d = bp.ex_target;
                    ctr_d = 2'd2;
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.ex_valid && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + STAT_W'(1);
        if (misp && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'd0;
            end
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (wr_en) begin
                valid_q[ex_idx] <= val_d;
                tag_q[ex_idx]   <= tag_d;
                tgt_q[ex_idx]   <= tgt_d;
                ctr_q[ex_idx]   <= ctr_d;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a
// behavioural BTB model; a second instance exercises stat saturation.
module tb_branch_predictor;
    localparam int AW = 24;
    localparam logic [AW-1:0] MASK = '1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(AW), .STAT_W(16)) bp ();
    branch_predictor_if #(.ADDR_W(AW), .STAT_W(4))  bp2 ();

    branch_predictor #(.ADDR_W(AW), .ENTRIES(16), .STAT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    branch_predictor #(.ADDR_W(AW), .ENTRIES(16), .STAT_W(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bp    (bp2.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: one remembered branch PC per slot, its target, counter value.
    bit            m_valid [16];
    logic [AW-1:0] m_pc    [16];
    logic [AW-1:0] m_tgt   [16];
    int            m_ctr   [16];
    int            m_bc, m_mc;

    logic [AW-1:0] pool [8];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [AW-1:0] pc);
        return m_valid[pc % 16] && (m_pc[pc % 16] == pc);
    endfunction

    function automatic bit m_pred(input logic [AW-1:0] pc);
        return m_hit(pc) && (m_ctr[pc % 16] >= 2);
    endfunction

    function automatic logic [AW-1:0] m_next(input logic [AW-1:0] pc);
        return m_pred(pc) ? m_tgt[pc % 16] : ((pc + 1) & MASK);
    endfunction

    function automatic bit m_misp();
        if (!bp.ex_valid) return 1'b0;
        if (bp.ex_taken != bp.ex_pred_taken) return 1'b1;
        return bp.ex_taken && (bp.ex_pred_target != bp.ex_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] redir;
        #1;
        redir = bp.ex_taken ? bp.ex_target : ((bp.ex_pc + 1) & MASK);
        chk({tag, ".pred_taken"}, 64'(bp.pred_taken), 64'(m_pred(bp.if_pc)));
        chk({tag, ".pred_next"}, 64'(bp.pred_next_pc),
            64'(m_next(bp.if_pc)));
        chk({tag, ".mispredict"}, 64'(bp.mispredict), 64'(m_misp()));
        if (bp.ex_valid)
            chk({tag, ".redirect"}, 64'(bp.redirect_pc), 64'(redir));
        chk({tag, ".branch_cnt"}, 64'(bp.branch_cnt), 64'(m_bc));
        chk({tag, ".mispred_cnt"}, 64'(bp.mispred_cnt), 64'(m_mc));
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit misp;
        int idx;
        misp = m_misp();
        idx  = int'(bp.ex_pc % 16);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (bp.ex_valid) begin
            m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
            if (misp) m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
            if (m_hit(bp.ex_pc)) begin
                if (bp.ex_taken) begin
                    m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = bp.ex_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (bp.ex_taken) begin
                m_valid[idx] = 1'b1;
                m_pc[idx]    = bp.ex_pc;
                m_tgt[idx]   = bp.ex_target;
                m_ctr[idx]   = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ex(input bit v, input logic [AW-1:0] pc,
                          input bit t, input logic [AW-1:0] tgt,
                          input bit pt, input logic [AW-1:0] ptgt);
        bp.ex_valid       = v;
        bp.ex_pc          = pc;
        bp.ex_taken       = t;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = pt;
        bp.ex_pred_target = ptgt;
    endtask

    initial begin
        pool = '{24'h000010, 24'h000020, 24'h000005, 24'h000015,
                 24'hFFFFFF, 24'h000030, 24'hABCDE3, 24'h000003};
        model_reset();
        reset = 1'b1;
        bp.if_pc = 24'h000010;
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        bp2.if_pc = '0;
        bp2.ex_valid = 1'b0;
        bp2.ex_pc = 24'h000040;
        bp2.ex_taken = 1'b1;
        bp2.ex_target = 24'h000080;
        bp2.ex_pred_taken = 1'b0;
        bp2.ex_pred_target = 24'h000041;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        bp.if_pc = 24'h000010;
        check_all("reset");
        chk("reset.next_lit", 64'(bp.pred_next_pc), 64'h11);

        // Taken miss allocates, mispredicted
        set_ex(1'b1, 24'h000010, 1'b1, 24'h000040, 1'b0, 24'h000011);
        check_all("alloc");
        chk("alloc.misp_lit", 64'(bp.mispredict), 64'h1);
        chk("alloc.redir_lit", 64'(bp.redirect_pc), 64'h40);
        tick();
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        check_all("after_alloc");
        chk("after_alloc.next_lit", 64'(bp.pred_next_pc), 64'h40);
        chk("after_alloc.cnt_lit", 64'({bp.branch_cnt, bp.mispred_cnt}),
            64'h0001_0001);

        // Hysteresis: two taken, then two not-taken
        repeat (2) begin
            set_ex(1'b1, 24'h000010, 1'b1, 24'h000040, 1'b1, 24'h000040);
            check_all("hyst_taken");
            tick();
        end
        set_ex(1'b1, 24'h000010, 1'b0, 24'h000040, 1'b1, 24'h000040);
        check_all("hyst_nt1");
        chk("hyst_nt1.misp_lit", 64'(bp.mispredict), 64'h1);
        tick();
        check_all("hyst_nt1_after");
        chk("hyst_nt1.still_taken", 64'(bp.pred_taken), 64'h1);
        // Same-index update and lookup: old contents visible
        check_all("same_cycle");
        chk("same_cycle.old_lit", 64'(bp.pred_next_pc), 64'h40);
        tick();
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        check_all("hyst_nt2");
        chk("hyst_nt2.next_lit", 64'(bp.pred_next_pc), 64'h11);

        // Aliasing at index 0
        bp.if_pc = 24'h000020;
        check_all("alias_miss");
        set_ex(1'b1, 24'h000020, 1'b1, 24'h000100, 1'b0, 24'h000021);
        tick();
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        check_all("alias_new");
        chk("alias_new.next_lit", 64'(bp.pred_next_pc), 64'h100);
        bp.if_pc = 24'h000010;
        check_all("alias_evicted");
        chk("alias_evicted.lit", 64'(bp.pred_taken), 64'h0);

        // Not-taken miss does not allocate
        set_ex(1'b1, 24'h000005, 1'b0, 24'h000077, 1'b0, 24'h000006);
        tick();
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        bp.if_pc = 24'h000005;
        check_all("nt_noalloc");

        // Address wrap
        set_ex(1'b1, 24'hFFFFFF, 1'b0, 24'h000123, 1'b0, 24'h000000);
        bp.if_pc = 24'hFFFFFF;
        check_all("wrap");
        chk("wrap.redir_lit", 64'(bp.redirect_pc), 64'h0);
        chk("wrap.next_lit", 64'(bp.pred_next_pc), 64'h0);
        tick();

        // Reset wins over ex_valid
        reset = 1'b1;
        set_ex(1'b1, 24'h000030, 1'b1, 24'h000200, 1'b0, 24'h000031);
        tick();
        reset = 1'b0;
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);
        bp.if_pc = 24'h000020;
        check_all("reset_mid");
        chk("reset_mid.cnt_lit", 64'({bp.branch_cnt, bp.mispred_cnt}), 64'h0);
        bp.if_pc = 24'h000030;
        check_all("reset_mid_noalloc");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] epc, etgt;
            bit et, ept;
            epc  = pool[$urandom_range(0, 7)];
            etgt = pool[$urandom_range(0, 7)] ^ AW'($urandom_range(0, 3));
            et   = 1'($urandom_range(0, 1));
            ept  = ($urandom_range(0, 3) != 0) ? m_pred(epc) : !m_pred(epc);
            set_ex(1'($urandom_range(0, 3) != 0), epc, et, etgt, ept,
                   ($urandom_range(0, 3) != 0) ? m_next(epc) : etgt);
            bp.if_pc = pool[$urandom_range(0, 7)];
            reset = ($urandom_range(0, 59) == 0);
            check_all("rand");
            tick();
        end
        reset = 1'b0;
        set_ex(1'b0, '0, 1'b0, '0, 1'b0, '0);

        // Stat saturation on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("sat.reset_bc", 64'(bp2.branch_cnt), 64'h0);
        bp2.ex_valid = 1'b1;
        #1;
        chk("sat.misp", 64'(bp2.mispredict), 64'h1);
        @(negedge clk);
        repeat (20) tick();
        bp2.ex_valid = 1'b0;
        #1;
        chk("sat.branch_cnt", 64'(bp2.branch_cnt), 64'hF);
        chk("sat.mispred_cnt", 64'(bp2.mispred_cnt), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined ASIP core. It predicts taken branches and jumps in IF, where the current core always resolves them in EX and flushes. It sits beside the PC register and supplies the next fetch address. It takes resolved outcomes from EX, flags mispredictions with a redirect PC, and keeps saturating statistics counters for the testbench.

## Interface
Parameters:
- ADDR_W, 24, PC/address width (word-addressed; sequential PC = PC + 1)
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES), TAG_W = ADDR_W − IDX_W
- STAT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- if_pc  in  ADDR_W  PC of instruction being fetched
- pred_taken  out  1  prediction for if_pc: 1 = taken
- pred_next_pc  out  ADDR_W  next fetch address: predicted target if pred_taken, else if_pc + 1
- ex_valid  in  1  EX holds a resolved branch/jump this cycle
- ex_pc  in  ADDR_W  PC of the resolved instruction
- ex_taken  in  1  actual outcome
- ex_target  in  ADDR_W  actual target (meaningful when ex_taken)
- ex_pred_taken  in  1  prediction made in IF, carried down the pipe
- ex_pred_target  in  ADDR_W  predicted next PC, carried down the pipe
- mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc
- redirect_pc  out  ADDR_W  ex_taken ? ex_target : ex_pc + 1
- branch_cnt  out  STAT_W  resolved branches since reset, saturating
- mispred_cnt  out  STAT_W  mispredictions since reset, saturating

## Operation
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2].
- Index = pc[IDX_W−1:0]; tag = pc[ADDR_W−1:IDX_W]. Direct-mapped.
- Lookup (combinational): hit = valid && tag match. pred_taken = hit && ctr[1].
- Mispredict (combinational): ex_valid && (ex_taken ≠ ex_pred_taken || (ex_taken && ex_pred_target ≠ ex_target)). Forced 0 when ex_valid = 0.
- Update on clock edge when ex_valid and not reset, at ex_pc's index:
  - Hit, taken: ctr = min(ctr + 1, 3); target = ex_target.
  - Hit, not taken: ctr = max(ctr − 1, 0); target unchanged.
  - Miss, taken: allocate. valid = 1, tag, target = ex_target, ctr = 2 (weakly taken). This replaces any aliasing entry.
  - Miss, not taken: no change.
- Stats on ex_valid:
  - branch_cnt += 1.
  - mispred_cnt += 1 if mispredict.
  - Both hold at all-ones.
- Arithmetic: if_pc + 1 and ex_pc + 1 are modulo 2^ADDR_W (all-ones wraps to 0).

## Timing
- Lookup latency 0: pred_taken and pred_next_pc follow if_pc in the same cycle.
- mispredict and redirect_pc are combinational from EX inputs in the same cycle.
- A table update becomes visible to lookup the cycle after ex_valid. If if_pc and ex_pc share an index in the same cycle, lookup returns the pre-update contents.
- Reset values: every valid = 0; branch_cnt = 0; mispred_cnt = 0. Hence pred_taken = 0 and pred_next_pc = if_pc + 1. mispredict still follows its combinational inputs.
- Reset asserted together with ex_valid: reset wins; no update, no count.
- Reset mid-stream: all predictions lost from the next cycle; no partial state survives.
- No stall input. The pipeline must present each resolved branch on ex_valid exactly once (deassert during stalls and bubbles).

## Test plan
- Reset, then if_pc = 0x000010: pred_taken = 0, pred_next_pc = 0x000011, branch_cnt = mispred_cnt = 0.
- ex_valid, ex_pc = 0x000010, ex_taken = 1, ex_target = 0x000040, ex_pred_taken = 0:
  - same cycle: mispredict = 1, redirect_pc = 0x000040.
  - next cycle, if_pc = 0x000010: pred_taken = 1, pred_next_pc = 0x000040; counts 1/1.
- Hysteresis on 0x000010 after allocation:
  - taken ×2: ctr 3.
  - not-taken ×1: still predicts taken; mispredict = 1 on that update.
  - second not-taken: pred_taken = 0, pred_next_pc = 0x000011.
- Aliasing (ENTRIES = 16): 0x000010 and 0x000020 map to index 0 with tags 1 and 2.
  - 0x000010 allocated: lookup 0x000020 misses.
  - Taken update at 0x000020, target 0x000100: 0x000020 predicts 0x000100, 0x000010 now misses.
  - Not-taken update at a missing PC 0x000005: no allocation; 0x000005 still misses.
- Boundaries:
  - ex_pc = 0xFFFFFF, not taken: redirect_pc = 0x000000.
  - Same-cycle update and lookup on the same index: old contents returned.
  - reset asserted with ex_valid: counts stay 0.
  - STAT_W = 4, 20 mispredicted branches: mispred_cnt = branch_cnt = 15.
